// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data memory (async read, sync write) between two requesters:
//   m0 = CPU load/store port, m1 = host/loader port. At most one access is
//   performed per cycle. Conflicts are resolved round-robin, and the first
//   conflict after reset goes to m0. Read data returns registered, one cycle
//   after the grant, together with a per-port valid strobe.
//
// Optional feature (macro DMEM_ARB_LOCK_EN):
//   - Adds the m0_lock and m1_lock inputs and the MAX_HOLD parameter.
//   - A locked grant gives that port exclusive ownership for up to MAX_HOLD
//     consecutive grants.
//   - With the macro undefined, the block is a pure round-robin arbiter.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   mN_req/we/addr/wd          request, write enable, word address, write data
//   mN_gnt                     access performed this cycle (combinational)
//   mN_rvalid/mN_rd            registered read data and its valid strobe
//   mem_a/mem_wd/mem_we        to dmem port a
//   mem_rd                     from dmem (async read data)
//   mN_lock                    lock request (DMEM_ARB_LOCK_EN only)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW     = 16,
    parameter int DATA_W = 32
`ifdef DMEM_ARB_LOCK_EN
    ,
    parameter int MAX_HOLD = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic [AW-1:0]     mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_LOCK_EN
    ,
    input  logic              m0_lock,
    input  logic              m1_lock
`endif
);

    // 0 = m0 was granted last, 1 = m1 was granted last
    logic last_gnt;
    // Effective ownership this cycle
    logic own0, own1;

`ifdef DMEM_ARB_LOCK_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;

    // Ownership only applies while the owner keeps its lock asserted.
    // Dropping the lock releases the memory in the same cycle.
    assign own0 = (state == ST_OWN0) && m0_lock;
    assign own1 = (state == ST_OWN1) && m1_lock;
`else
    assign own0 = 1'b0;
    assign own1 = 1'b0;
`endif

    // Grant selection and memory port mux
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst_n) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end else if (own0) begin
            m0_gnt = m0_req;
        end else if (own1) begin
            m1_gnt = m1_req;
        end else if (m0_req && (!m1_req || last_gnt)) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end

        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (m0_gnt) begin
            mem_a  = m0_addr;
            mem_wd = m0_wd;
            mem_we = m0_we;
        end else if (m1_gnt) begin
            mem_a  = m1_addr;
            mem_wd = m1_wd;
            mem_we = m1_we;
        end
    end

    // Round-robin history and registered read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rd     <= '0;
            m1_rd     <= '0;
        end else begin
            if (m0_gnt) begin
                last_gnt <= 1'b0;
            end else if (m1_gnt) begin
                last_gnt <= 1'b1;
            end
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rd <= mem_rd;
            end
            if (m1_gnt && !m1_we) begin
                m1_rd <= mem_rd;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock FSM. hold_cnt counts grants already given during the current
    // ownership. A forced exit leaves last_gnt pointing at the owner,
    // so the other port wins the next conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else if (own0 || own1) begin
            if (m0_gnt || m1_gnt) begin
                if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end else if (m0_gnt && m0_lock && (MAX_HOLD > 1)) begin
            state    <= ST_OWN0;
            hold_cnt <= HW'(1);
        end else if (m1_gnt && m1_lock && (MAX_HOLD > 1)) begin
            state    <= ST_OWN1;
            hold_cnt <= HW'(1);
        end else begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int AW     = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0]     m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wd, m1_wd;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rd, m1_rd;
    logic [AW-1:0]     mem_a;
    logic [DATA_W-1:0] mem_wd, mem_rd;
    logic              mem_we;
    logic              m0_lock, m1_lock;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef DMEM_ARB_LOCK_EN
        , .m0_lock(m0_lock), .m1_lock(m1_lock)
`endif
    );

    // Data memory: async read, sync write; word i preloaded with 0x01020101 + 2*i
    logic [DATA_W-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h01020101 + 32'(2 * i);
    end
    assign mem_rd = mem[mem_a[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[3:0]] <= mem_wd;

    typedef struct {
        logic r0, w0; logic [15:0] a0; logic [31:0] d0;
        logic r1, w1; logic [15:0] a1; logic [31:0] d1;
        logic eg0, eg1, ewe; logic [15:0] ea; logic [31:0] ewd;
        logic ev0; logic [31:0] erd0;
        logic ev1; logic [31:0] erd1;
    } vec_t;

    function automatic vec_t mkv(
        logic r0, logic w0, logic [15:0] a0, logic [31:0] d0,
        logic r1, logic w1, logic [15:0] a1, logic [31:0] d1,
        logic eg0, logic eg1, logic ewe, logic [15:0] ea, logic [31:0] ewd,
        logic ev0, logic [31:0] erd0, logic ev1, logic [31:0] erd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
        v.ev0 = ev0; v.erd0 = erd0; v.ev1 = ev1; v.erd1 = erd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wd = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wd = d1;
    endtask

    vec_t vecs [20];

    initial begin
        // Contention: alternating grants, rvalid one cycle behind
        vecs[0]  = mkv(1,0,1,0, 1,0,3,0,  1,0,0,1,0,  0,0,           0,0);
        vecs[1]  = mkv(1,0,1,0, 1,0,3,0,  0,1,0,3,0,  1,32'h01020103, 0,0);
        vecs[2]  = mkv(1,0,1,0, 1,0,3,0,  1,0,0,1,0,  0,0,           1,32'h01020107);
        vecs[3]  = mkv(1,0,1,0, 1,0,3,0,  0,1,0,3,0,  1,32'h01020103, 0,0);
        vecs[4]  = mkv(1,0,1,0, 1,0,3,0,  1,0,0,1,0,  0,0,           1,32'h01020107);
        vecs[5]  = mkv(1,0,1,0, 1,0,3,0,  0,1,0,3,0,  1,32'h01020103, 0,0);
        vecs[6]  = mkv(0,0,0,0, 0,0,0,0,  0,0,0,0,0,  0,0,           1,32'h01020107);
        // Single read of address 2
        vecs[7]  = mkv(1,0,2,0, 0,0,0,0,  1,0,0,2,0,  0,0,           0,0);
        vecs[8]  = mkv(0,0,0,0, 0,0,0,0,  0,0,0,0,0,  1,32'h01020105, 0,0);
        // m1 writes address 6, m0 reads it back
        vecs[9]  = mkv(0,0,0,0, 1,1,6,32'hDEADBEEF, 0,1,1,6,32'hDEADBEEF, 0,0, 0,0);
        vecs[10] = mkv(1,0,6,0, 0,0,0,0,  1,0,0,6,0,  0,0,           0,0);
        vecs[11] = mkv(0,0,0,0, 0,0,0,0,  0,0,0,0,0,  1,32'hDEADBEEF, 0,0);
        // m1 alone back-to-back, then both: m0 wins
        vecs[12] = mkv(0,0,0,0, 1,0,4,0,  0,1,0,4,0,  0,0,           0,0);
        vecs[13] = mkv(0,0,0,0, 1,0,4,0,  0,1,0,4,0,  0,0,           1,32'h01020109);
        vecs[14] = mkv(0,0,0,0, 1,0,4,0,  0,1,0,4,0,  0,0,           1,32'h01020109);
        vecs[15] = mkv(0,0,0,0, 1,0,4,0,  0,1,0,4,0,  0,0,           1,32'h01020109);
        vecs[16] = mkv(1,0,5,0, 1,0,7,0,  1,0,0,5,0,  0,0,           1,32'h01020109);
        // m0 writes address 9, m1 reads it next cycle
        vecs[17] = mkv(1,1,9,32'h12345678, 0,0,0,0, 1,0,1,9,32'h12345678, 1,32'h0102010B, 0,0);
        vecs[18] = mkv(0,0,0,0, 1,0,9,0,  0,1,0,9,0,  0,0,           0,0);
        vecs[19] = mkv(0,0,0,0, 0,0,0,0,  0,0,0,0,0,  0,0,           1,32'h12345678);

        m0_lock = 1'b0; m1_lock = 1'b0;
        drive(0,0,0,0, 0,0,0,0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        chk("rst gnt0", 32'(m0_gnt), 0);
        chk("rst gnt1", 32'(m1_gnt), 0);
        chk("rst rvalid0", 32'(m0_rvalid), 0);
        chk("rst rvalid1", 32'(m1_rvalid), 0);
        chk("rst rd0", m0_rd, 0);
        chk("rst mem_a", 32'(mem_a), 0);
        drive(0,0,0,0, 0,0,0,0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d gnt0", i), 32'(m0_gnt), 32'(vecs[i].eg0));
            chk($sformatf("v%0d gnt1", i), 32'(m1_gnt), 32'(vecs[i].eg1));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].ewe));
            chk($sformatf("v%0d mem_a", i), 32'(mem_a), 32'(vecs[i].ea));
            chk($sformatf("v%0d mem_wd", i), mem_wd, vecs[i].ewd);
            chk($sformatf("v%0d rvalid0", i), 32'(m0_rvalid), 32'(vecs[i].ev0));
            chk($sformatf("v%0d rvalid1", i), 32'(m1_rvalid), 32'(vecs[i].ev1));
            if (vecs[i].ev0) chk($sformatf("v%0d rd0", i), m0_rd, vecs[i].erd0);
            if (vecs[i].ev1) chk($sformatf("v%0d rd1", i), m1_rd, vecs[i].erd1);
            @(posedge clk); #1;
        end

        // Reset asserted while a read result is pending and both ports request
        drive(1,0,2,0, 0,0,0,0);
        @(posedge clk); #1;
        chk("pre-reset rvalid0", 32'(m0_rvalid), 1);
        m1_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst gnt0", 32'(m0_gnt), 0);
        chk("midrst gnt1", 32'(m1_gnt), 0);
        chk("midrst rvalid0", 32'(m0_rvalid), 0);
        chk("midrst mem_we", 32'(mem_we), 0);
        chk("midrst mem_a", 32'(mem_a), 0);
        chk("midrst rd0", m0_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst gnt0", 32'(m0_gnt), 1);
        chk("postrst gnt1", 32'(m1_gnt), 0);
        @(posedge clk); #1;
        chk("postrst rvalid0 after grant", 32'(m0_rvalid), 1);
        chk("postrst rd0", m0_rd, 32'h01020105);

`ifdef DMEM_ARB_LOCK_EN
        // m1 locks under continuous contention: 8 m1 grants, then m0
        drive(1,0,1,0, 1,0,3,0);
        m1_lock = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("lock8 c%0d gnt1", k), 32'(m1_gnt), (k < 8) ? 1 : 0);
            chk($sformatf("lock8 c%0d gnt0", k), 32'(m0_gnt), (k < 8) ? 0 : 1);
            @(posedge clk); #1;
        end
        // Lock held for 3 grants then dropped: m0 granted on the 4th cycle
        for (int k = 0; k < 4; k++) begin
            m1_lock = (k < 3);
            #1;
            @(negedge clk);
            chk($sformatf("lock3 c%0d gnt1", k), 32'(m1_gnt), (k < 3) ? 1 : 0);
            chk($sformatf("lock3 c%0d gnt0", k), 32'(m0_gnt), (k < 3) ? 0 : 1);
            @(posedge clk); #1;
        end
        m1_lock = 1'b0;
`endif

        drive(0,0,0,0, 0,0,0,0);
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
